// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle of uart_rx_param: word, flags, valid/ready and overrun pulse.
// The receiver drives through the master modport, the consumer through the slave modport.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 5..8 data bits, optional even/odd parity, 1 or 2 stop bits,
// mid-bit sampling and a one-word valid/ready output holding register with overrun reporting.
module uart_rx_param #(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_pin,
    uart_rx_param_if.master  rx_if
);

    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CNT_W = ($clog2(CYCLE + 1) > 16) ? $clog2(CYCLE + 1) : 16;
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(CYCLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CYCLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE    = {{(BIT_W-1){1'b0}}, 1'b1};
    localparam logic             LAST_STOP  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic             ODD_BIT    = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    localparam logic             HAS_PARITY = (PARITY_EN != 0) ? 1'b1 : 1'b0;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // True when the received parity bit does not give the configured overall parity.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data, input logic pbit);
        return ((^data) ^ pbit) != ODD_BIT;
    endfunction

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 line_prev_q, line_prev_d;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic                 fall_s;
    logic                 at_sample_s;
    logic                 at_last_s;
    logic                 frame_done_s;

    assign fall_s      = line_prev_q & ~sync2_q;
    assign at_sample_s = (cnt_q == SAMPLE_CNT);
    assign at_last_s   = (cnt_q == LAST_CNT);

    // Frame sequencer: synchronizer, baud counter, bit counters and sample accumulation.
    always_comb begin
        sync1_d      = rx_pin;
        sync2_d      = sync1_q;
        line_prev_d  = sync2_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        shift_d      = shift_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        frame_done_s = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                perr_acc_d = 1'b0;
                ferr_acc_d = 1'b0;
                if (fall_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                // A line already back high at mid start bit is noise, not a frame.
                if (at_sample_s && sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (at_last_s) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                // LSB arrives first, so shifting in from the top leaves bit 0 at the bottom.
                if (at_sample_s) begin
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (at_last_s) begin
                    cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        state_d    = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PARITY: begin
                if (at_sample_s) begin
                    perr_acc_d = parity_mismatch(shift_q, sync2_q);
                end else begin
                    perr_acc_d = perr_acc_q;
                end
                if (at_last_s) begin
                    cnt_d      = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (at_sample_s) begin
                    if (!sync2_q) begin
                        ferr_acc_d = 1'b1;
                    end else begin
                        ferr_acc_d = ferr_acc_q;
                    end
                    // Finish at mid last stop bit so a back-to-back start edge is not missed.
                    if (stop_cnt_q == LAST_STOP) begin
                        frame_done_s = 1'b1;
                        state_d      = IDLE;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (at_last_s) begin
                    stop_cnt_d = ~stop_cnt_q;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output holding register: load on completion unless a held word is still unaccepted.
    always_comb begin
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_valid_d   = rx_valid_q;
        overrun_d    = 1'b0;
        if (frame_done_s) begin
            if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = perr_acc_q;
                frame_err_d  = ferr_acc_q | ~sync2_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            line_prev_q  <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            line_prev_q  <= line_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            shift_q      <= shift_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four configurations (8N1 at 434 clocks/bit, 8E1, 8N2, 5O2 at 16 clocks/bit),
// a vector table, hand sequences for glitch/overrun/break/reset, and random frames against a reference model.
module tb_uart_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx_pin_a   [4];
    logic       rx_ready_a [4];
    wire  [7:0] data_a     [4];
    wire        valid_a    [4];
    wire        perr_a     [4];
    wire        ferr_a     [4];
    wire        ovr_a      [4];

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();
    uart_rx_param_if #(.DATA_BITS(8)) if2 ();
    uart_rx_param_if #(.DATA_BITS(5)) if3 ();

    uart_rx_param u0 (.clk(clk), .rst(rst), .rx_pin(rx_pin_a[0]), .rx_if(if0));
    uart_rx_param #(.CLK_FRE(1), .BAUD_RATE(62500), .PARITY_EN(1), .PARITY_ODD(0))
        u1 (.clk(clk), .rst(rst), .rx_pin(rx_pin_a[1]), .rx_if(if1));
    uart_rx_param #(.CLK_FRE(1), .BAUD_RATE(62500), .STOP_BITS(2))
        u2 (.clk(clk), .rst(rst), .rx_pin(rx_pin_a[2]), .rx_if(if2));
    uart_rx_param #(.CLK_FRE(1), .BAUD_RATE(62500), .DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
        u3 (.clk(clk), .rst(rst), .rx_pin(rx_pin_a[3]), .rx_if(if3));

    assign if0.rx_ready = rx_ready_a[0];
    assign if1.rx_ready = rx_ready_a[1];
    assign if2.rx_ready = rx_ready_a[2];
    assign if3.rx_ready = rx_ready_a[3];
    assign data_a[0] = if0.rx_data;
    assign data_a[1] = if1.rx_data;
    assign data_a[2] = if2.rx_data;
    assign data_a[3] = {3'b000, if3.rx_data};
    assign valid_a[0] = if0.rx_valid;
    assign valid_a[1] = if1.rx_valid;
    assign valid_a[2] = if2.rx_valid;
    assign valid_a[3] = if3.rx_valid;
    assign perr_a[0] = if0.parity_err;
    assign perr_a[1] = if1.parity_err;
    assign perr_a[2] = if2.parity_err;
    assign perr_a[3] = if3.parity_err;
    assign ferr_a[0] = if0.frame_err;
    assign ferr_a[1] = if1.frame_err;
    assign ferr_a[2] = if2.frame_err;
    assign ferr_a[3] = if3.frame_err;
    assign ovr_a[0] = if0.overrun;
    assign ovr_a[1] = if1.overrun;
    assign ovr_a[2] = if2.overrun;
    assign ovr_a[3] = if3.overrun;

    function automatic int cfg_cyc(input int k);
        return (k == 0) ? 434 : 16;
    endfunction
    function automatic int cfg_nb(input int k);
        return (k == 3) ? 5 : 8;
    endfunction
    function automatic bit cfg_par(input int k);
        return (k == 1) || (k == 3);
    endfunction
    function automatic bit cfg_odd(input int k);
        return (k == 3);
    endfunction
    function automatic int cfg_ns(input int k);
        return (k >= 2) ? 2 : 1;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    typedef struct {
        int         k;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } obs_t;

    typedef struct {
        int         k;
        logic [7:0] d;
        logic       p;
        logic       s1;
        logic       s2;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t obs_q[$];
    int   vcnt [4] = '{0, 0, 0, 0};
    int   ocnt [4] = '{0, 0, 0, 0};
    vec_t vecs [13];

    // Reference: what a frame with these line bits must deliver.
    function automatic exp_t model(input int k, input logic [7:0] d, input logic pbit,
                                   input logic s1, input logic s2);
        exp_t       e;
        logic [7:0] all_ones = 8'hFF;
        logic [7:0] mask     = all_ones >> (8 - cfg_nb(k));
        e.d  = d & mask;
        e.pe = cfg_par(k) ? (((^e.d) ^ pbit) != cfg_odd(k)) : 1'b0;
        e.fe = !s1 || ((cfg_ns(k) == 2) && !s2);
        return e;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (valid_a[k]) vcnt[k] <= vcnt[k] + 1;
            if (ovr_a[k])   ocnt[k] <= ocnt[k] + 1;
            if (valid_a[k] && rx_ready_a[k]) obs_q.push_back('{k, data_a[k], perr_a[k], ferr_a[k]});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int k, input logic [7:0] d, input logic pbit,
                              input logic s1, input logic s2);
        int c;
        c = cfg_cyc(k);
        rx_pin_a[k] = 1'b0;
        wait_cyc(c);
        for (int i = 0; i < cfg_nb(k); i++) begin
            rx_pin_a[k] = d[i];
            wait_cyc(c);
        end
        if (cfg_par(k)) begin
            rx_pin_a[k] = pbit;
            wait_cyc(c);
        end
        rx_pin_a[k] = s1;
        wait_cyc(c);
        if (cfg_ns(k) == 2) begin
            rx_pin_a[k] = s2;
            wait_cyc(c);
        end
        rx_pin_a[k] = 1'b1;
    endtask

    // Compare the next delivered word as one packed record: {dut, data, parity_err, frame_err}.
    task automatic check_next(input int k, input exp_t e, input string name);
        obs_t o;
        if (obs_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no word delivered, expected data %h", name, e.d);
        end else begin
            o = obs_q.pop_front();
            check(name, {8'(o.k), o.d, 7'd0, o.pe, 7'd0, o.fe},
                        {8'(k), e.d, 7'd0, e.pe, 7'd0, e.fe});
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   v0;
        int   o0;
        exp_t e;
        logic [7:0] d;
        logic p, s1, s2;
        int   kk;

        vecs[0]  = '{1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[1]  = '{1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[2]  = '{1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3]  = '{1, 8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[4]  = '{1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
        vecs[5]  = '{2, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};
        vecs[6]  = '{2, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
        vecs[7]  = '{2, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[8]  = '{3, 8'h1F, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
        vecs[9]  = '{3, 8'h13, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 1'b0};
        vecs[10] = '{3, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{3, 8'hE6, 1'b1, 1'b1, 1'b1, 8'h06, 1'b0, 1'b0};
        vecs[12] = '{1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rx_pin_a[k]   = 1'b1;
            rx_ready_a[k] = 1'b1;
        end
        wait_cyc(3);
        for (int k = 0; k < 4; k++)
            check($sformatf("reset_k%0d", k),
                  {16'd0, data_a[k], 3'd0, valid_a[k], perr_a[k], ferr_a[k], ovr_a[k], 1'b0}, 32'd0);
        rst = 1'b0;
        wait_cyc(4);

        // Default 8N1: one clean word, single-cycle valid with rx_ready held high.
        v0 = vcnt[0];
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        wait_cyc(20);
        check_next(0, '{8'hA5, 1'b0, 1'b0}, "dflt_a5");
        check("dflt_valid_width", vcnt[0] - v0, 32'd1);

        foreach (vecs[i]) begin
            send_frame(vecs[i].k, vecs[i].d, vecs[i].p, vecs[i].s1, vecs[i].s2);
            wait_cyc(4);
            check_next(vecs[i].k, '{vecs[i].ed, vecs[i].epe, vecs[i].efe}, $sformatf("vec%0d", i));
        end

        // Break on 8N2: word 0 with frame error, then silence until the line recovers.
        rx_pin_a[2] = 1'b0;
        wait_cyc(16 * 11 + 40);
        check_next(2, '{8'h00, 1'b0, 1'b1}, "break_word");
        wait_cyc(200);
        check("break_no_repeat", obs_q.size(), 32'd0);
        rx_pin_a[2] = 1'b1;
        wait_cyc(20);
        send_frame(2, 8'h5A, 1'b0, 1'b1, 1'b1);
        wait_cyc(4);
        check_next(2, '{8'h5A, 1'b0, 1'b0}, "after_break");

        // 100-cycle glitch shorter than half a bit must be rejected.
        v0 = vcnt[0];
        rx_pin_a[0] = 1'b0;
        wait_cyc(100);
        rx_pin_a[0] = 1'b1;
        wait_cyc(700);
        check("glitch_no_valid", vcnt[0] - v0, 32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
        wait_cyc(20);
        check_next(0, '{8'h3C, 1'b0, 1'b0}, "after_glitch");

        // Overrun: consumer stalled, second back-to-back word dropped.
        rx_ready_a[0] = 1'b0;
        o0 = ocnt[0];
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
        wait_cyc(20);
        check("ovr_valid_held", {31'd0, valid_a[0]}, 32'd1);
        check("ovr_data_held", {24'd0, data_a[0]}, 32'h11);
        check("ovr_pulse_cycles", ocnt[0] - o0, 32'd1);
        rx_ready_a[0] = 1'b1;
        wait_cyc(3);
        check_next(0, '{8'h11, 1'b0, 1'b0}, "ovr_drain");
        check("ovr_valid_cleared", {31'd0, valid_a[0]}, 32'd0);

        // Reset at mid data bit 4 of 0xF0; the rest of that frame is high, so no edge follows.
        rx_pin_a[0] = 1'b0;
        wait_cyc(434 * 5);
        rx_pin_a[0] = 1'b1;
        wait_cyc(217);
        rst = 1'b1;
        wait_cyc(2);
        check("midreset_outputs",
              {16'd0, data_a[0], 3'd0, valid_a[0], perr_a[0], ferr_a[0], ovr_a[0], 1'b0}, 32'd0);
        rst = 1'b0;
        v0 = vcnt[0];
        wait_cyc(434 * 5);
        check("midreset_no_valid", vcnt[0] - v0, 32'd0);
        send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b1);
        wait_cyc(20);
        check_next(0, '{8'h7E, 1'b0, 1'b0}, "after_reset");

        // Random frames on the fast parity configurations, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 2; j++) begin
                kk = (j == 0) ? 1 : 3;
                d  = 8'($urandom);
                p  = 1'($urandom);
                s1 = ($urandom_range(0, 4) != 0);
                s2 = ($urandom_range(0, 4) != 0);
                e  = model(kk, d, p, s1, s2);
                send_frame(kk, d, p, s1, s2);
                check_next(kk, e, $sformatf("rand%0d_k%0d", i, kk));
                if ((cfg_ns(kk) == 1 && !s1) || (cfg_ns(kk) == 2 && !s2))
                    wait_cyc(2 + $urandom_range(0, 3));
                else
                    wait_cyc($urandom_range(0, 2));
            end
        end

        wait_cyc(40);
        check("no_spurious_words", obs_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
